// File: rtl/cu_pkg.sv
// cu_pkg: shared state codes, opcode constants and opcode-class encoding for the control unit.
package cu_pkg;

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADDR  = 5'd2,
        S_MEMREAD  = 5'd3,
        S_LOADWB   = 5'd4,
        S_MEMWRITE = 5'd5,
        S_REXEC    = 5'd6,
        S_ALUWB    = 5'd7,
        S_BRCMP    = 5'd8,
        S_JLINK    = 5'd9,
        S_JAL      = 5'd10,
        S_AUIPC    = 5'd11,
        S_JALR     = 5'd12,
        S_IEXEC    = 5'd13,
        S_BRANCH   = 5'd14,
        S_LUI      = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // IMM, AUIPC and LUI share one class: they differ only in their DECODE
    // target, which is resolved from the live opcode while in DECODE.
    typedef enum logic [2:0] {
        CL_LOAD    = 3'd0,
        CL_STORE   = 3'd1,
        CL_R       = 3'd2,
        CL_BRANCH  = 3'd3,
        CL_JAL     = 3'd4,
        CL_JALR    = 3'd5,
        CL_UIMM    = 3'd6,
        CL_ILLEGAL = 3'd7
    } cls_t;

endpackage

// File: rtl/cu_opclass.sv
// cu_opclass: combinational opcode-to-class mapper.
//   opcode in  7  instruction opcode field IR[6:0]
//   cls    out 3  opcode class (cls_t)
module cu_opclass
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_LOAD:                    cls = CL_LOAD;
            OP_STORE:                   cls = CL_STORE;
            OP_R:                       cls = CL_R;
            OP_BRANCH:                  cls = CL_BRANCH;
            OP_JAL:                     cls = CL_JAL;
            OP_JALR:                    cls = CL_JALR;
            OP_IMM, OP_AUIPC, OP_LUI:   cls = CL_UIMM;
            default:                    cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: multicycle control-unit sequencer (state register, next-state logic, retire counter).
//   clk           in  1          rising-edge clock
//   reset         in  1          asynchronous active-high reset
//   opcode        in  7          IR[6:0], used only in DECODE
//   mem_ready     in  1          memory completion, used only in FETCH/MEMREAD/MEMWRITE
//   stall         in  1          freezes state, class register and instret
//   state         out 5          current state code
//   illegal_instr out 1          high while in TRAP
//   instret       out INSTRET_W  retired-instruction count (wraps)
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int INSTRET_W   = 32,
    parameter int TRAP_STICKY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 stall,
    output logic [4:0]           state,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    state_t state_q, nxt;
    cls_t   op_cls, cls_q;
    logic   retire;

    cu_opclass u_opclass (
        .opcode (opcode),
        .cls    (op_cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CL_LOAD;
            instret <= '0;
        end else if (!stall) begin
            state_q <= nxt;
            if (state_q == S_DECODE)
                cls_q <= op_cls;
            if (retire)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        nxt = S_FETCH;
        case (state_q)
            S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_cls)
                    CL_LOAD, CL_STORE: nxt = S_MEMADDR;
                    CL_R:              nxt = S_REXEC;
                    CL_BRANCH:         nxt = S_BRCMP;
                    CL_JAL, CL_JALR:   nxt = S_JLINK;
                    // bit2 clear -> OP-IMM; else bit5 separates LUI from AUIPC
                    CL_UIMM:           nxt = !opcode[2] ? S_IEXEC : (opcode[5] ? S_LUI : S_AUIPC);
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADDR:  nxt = (cls_q == CL_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt = mem_ready ? S_LOADWB : S_MEMREAD;
            S_LOADWB:   nxt = S_FETCH;
            S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            S_REXEC:    nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRCMP:    nxt = S_BRANCH;
            S_BRANCH:   nxt = S_FETCH;
            S_JLINK:    nxt = (cls_q == CL_JALR) ? S_JALR : S_JAL;
            S_JAL:      nxt = S_FETCH;
            S_JALR:     nxt = S_FETCH;
            S_AUIPC:    nxt = S_ALUWB;
            S_IEXEC:    nxt = S_ALUWB;
            S_LUI:      nxt = S_ALUWB;
            S_TRAP:     nxt = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
            default:    nxt = S_FETCH;
        endcase
    end

    // Only completing states retire; TRAP returning to FETCH does not.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_LOADWB, S_MEMWRITE, S_ALUWB, S_JAL, S_JALR, S_BRANCH: retire = (nxt == S_FETCH);
            default:                                                retire = 1'b0;
        endcase
    end

    assign state         = state_q;
    assign illegal_instr = (state_q == S_TRAP);

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: scoreboard bench for cu_sequencer (sticky, non-sticky and 4-bit counter instances).
module tb_cu_sequencer;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] STO = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] IM  = 7'b0010011;
    localparam logic [6:0] AU  = 7'b0010111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] ILL = 7'b1111111;

    typedef struct {
        int          w;
        logic [4:0]  st;
        logic [31:0] ir;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset0 = 1'b1, reset1 = 1'b1, reset2 = 1'b1;
    logic [6:0]  opcode = RT;
    logic        mem_ready = 1'b1;
    logic        stall = 1'b0;
    logic [4:0]  s0, s1, s2;
    logic        l0, l1, l2;
    logic [31:0] i0, i1;
    logic [3:0]  i2;
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cu_sequencer #(.INSTRET_W(32), .TRAP_STICKY(1)) dut0 (
        .clk(clk), .reset(reset0), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .state(s0), .illegal_instr(l0), .instret(i0));
    cu_sequencer #(.INSTRET_W(32), .TRAP_STICKY(0)) dut1 (
        .clk(clk), .reset(reset1), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .state(s1), .illegal_instr(l1), .instret(i1));
    cu_sequencer #(.INSTRET_W(4), .TRAP_STICKY(1)) dut2 (
        .clk(clk), .reset(reset2), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .state(s2), .illegal_instr(l2), .instret(i2));

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t        e;
            logic [4:0]  as;
            logic [31:0] ai;
            logic        al;
            e  = q.pop_front();
            as = (e.w == 0) ? s0 : (e.w == 1) ? s1 : s2;
            ai = (e.w == 0) ? i0 : (e.w == 1) ? i1 : {28'd0, i2};
            al = (e.w == 0) ? l0 : (e.w == 1) ? l1 : l2;
            checks++;
            if (as !== e.st || ai !== e.ir || al !== (e.st == 5'd16)) begin
                failures++;
                $display("FAIL %s dut%0d: got state=%0d instret=%0d illegal=%0b, want state=%0d instret=%0d illegal=%0b",
                         e.nm, e.w, as, ai, al, e.st, e.ir, (e.st == 5'd16));
            end
        end
    end

    task automatic cyc(input logic [6:0] op, input logic mr, input logic sl, input int w,
                       input logic [4:0] es, input logic [31:0] ei, input string nm);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        stall     = sl;
        e = '{w, es, ei, nm};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic four(input logic [6:0] op, input int w, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] ir, input string nm);
        cyc(op, 1'b1, 1'b0, w, 5'd0, ir, nm);
        cyc(op, 1'b1, 1'b0, w, 5'd1, ir, nm);
        cyc(op, 1'b1, 1'b0, w, a, ir, nm);
        cyc(op, 1'b1, 1'b0, w, b, ir, nm);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(RT, 1'b1, 1'b0, 0, 5'd0, 0, "reset");
        reset0 = 1'b0;
        four(RT, 0, 5'd6, 5'd7, 0, "rtype");
        cyc(LD, 1'b1, 1'b0, 0, 5'd0, 1, "load");
        cyc(LD, 1'b1, 1'b0, 0, 5'd1, 1, "load");
        cyc(LD, 1'b1, 1'b0, 0, 5'd2, 1, "load");
        cyc(LD, 1'b0, 1'b0, 0, 5'd3, 1, "load_wait");
        cyc(LD, 1'b0, 1'b0, 0, 5'd3, 1, "load_wait");
        cyc(LD, 1'b1, 1'b0, 0, 5'd3, 1, "load_wait");
        cyc(LD, 1'b1, 1'b0, 0, 5'd4, 1, "load");
        cyc(STO, 1'b0, 1'b0, 0, 5'd0, 2, "fetch_wait");
        cyc(STO, 1'b1, 1'b0, 0, 5'd0, 2, "fetch_wait");
        cyc(STO, 1'b1, 1'b0, 0, 5'd1, 2, "store");
        cyc(STO, 1'b1, 1'b0, 0, 5'd2, 2, "store");
        cyc(STO, 1'b0, 1'b0, 0, 5'd5, 2, "store_wait");
        cyc(STO, 1'b1, 1'b0, 0, 5'd5, 2, "store");
        four(JL, 0, 5'd9, 5'd10, 3, "jal");
        cyc(JR, 1'b1, 1'b0, 0, 5'd0, 4, "jalr");
        cyc(JR, 1'b1, 1'b0, 0, 5'd1, 4, "jalr");
        cyc(RT, 1'b1, 1'b0, 0, 5'd9, 4, "jalr_latched");
        cyc(RT, 1'b1, 1'b0, 0, 5'd12, 4, "jalr_latched");
        four(BR, 0, 5'd8, 5'd14, 5, "branch");
        four(IM, 0, 5'd13, 5'd7, 6, "imm");
        four(AU, 0, 5'd11, 5'd7, 7, "auipc");
        four(LU, 0, 5'd15, 5'd7, 8, "lui");
        cyc(RT, 1'b1, 1'b0, 0, 5'd0, 9, "stall_r");
        cyc(RT, 1'b0, 1'b0, 0, 5'd1, 9, "decode_ignores_mr");
        cyc(RT, 1'b1, 1'b1, 0, 5'd6, 9, "stall_hold");
        cyc(RT, 1'b1, 1'b1, 0, 5'd6, 9, "stall_hold");
        cyc(RT, 1'b1, 1'b1, 0, 5'd6, 9, "stall_hold");
        cyc(RT, 1'b1, 1'b0, 0, 5'd6, 9, "stall_release");
        cyc(RT, 1'b1, 1'b0, 0, 5'd7, 9, "stall_r");
        cyc(LD, 1'b1, 1'b1, 0, 5'd0, 10, "stall_beats_mr");
        cyc(LD, 1'b0, 1'b0, 0, 5'd0, 10, "fetch_wait");
        cyc(LD, 1'b1, 1'b0, 0, 5'd0, 10, "load2");
        cyc(LD, 1'b1, 1'b0, 0, 5'd1, 10, "load2");
        cyc(LD, 1'b1, 1'b0, 0, 5'd2, 10, "load2");
        cyc(LD, 1'b0, 1'b0, 0, 5'd3, 10, "load2");
        reset0 = 1'b1;
        cyc(LD, 1'b1, 1'b0, 0, 5'd0, 0, "reset_mid_s3");
        reset0 = 1'b0;
        cyc(ILL, 1'b1, 1'b0, 0, 5'd0, 0, "trap");
        cyc(ILL, 1'b1, 1'b0, 0, 5'd1, 0, "trap");
        for (int i = 0; i < 10; i++)
            cyc(RT, 1'b1, 1'b0, 0, 5'd16, 0, "trap_sticky");
        reset0 = 1'b1;
        reset1 = 1'b0;
        cyc(ILL, 1'b1, 1'b0, 1, 5'd0, 0, "trap_ns");
        cyc(ILL, 1'b1, 1'b0, 1, 5'd1, 0, "trap_ns");
        cyc(ILL, 1'b1, 1'b0, 1, 5'd16, 0, "trap_ns");
        four(RT, 1, 5'd6, 5'd7, 0, "trap_ns_return");
        cyc(RT, 1'b1, 1'b0, 1, 5'd0, 1, "ns_retire");
        reset1 = 1'b1;
        reset2 = 1'b0;
        for (int i = 0; i < 17; i++)
            four(RT, 2, 5'd6, 5'd7, i % 16, "wrap");
        cyc(RT, 1'b1, 1'b0, 2, 5'd0, 1, "wrap_final");
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Multicycle control-unit sequencer for the RISC-V core: the state register and next-state logic that walks each instruction through fetch, decode, execute, memory and writeback. Its 5-bit `state` output drives the control-unit output decoder, which turns it into datapath strobes (PCWrite, IRWrite, ALUSrc*, RegWrite, …). The sequencer also waits on memory, honours an external stall, traps illegal opcodes and counts retired instructions.

## Interface
- `INSTRET_W`, 32, width of the retired-instruction counter.
- `TRAP_STICKY`, 1; 1 = trap state holds until reset, 0 = trap lasts one cycle and then returns to fetch.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  7  IR[6:0]; sampled only in DECODE.
- `mem_ready`  in  1  memory completion; sampled only in S0, S3 and S5.
- `stall`  in  1  freezes all state; overrides `mem_ready`.
- `state`  out  5  current state, a direct register output.
- `illegal_instr`  out  1  high while `state`==16.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- States: 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 LOADWB, 5 MEMWRITE, 6 REXEC, 7 ALUWB, 8 BRCMP, 9 JLINK, 10 JAL, 11 AUIPC, 12 JALR, 13 IEXEC, 14 BRANCH, 15 LUI, 16 TRAP. Codes 17–31 are unreachable; if entered, next state is 0.
- Transitions:
  - 0→1 when `mem_ready`, else hold.
  - 1→ by opcode:
    - 0000011 or 0100011 → 2.
    - 0110011 → 6.
    - 1100011 → 8.
    - 1101111 or 1100111 → 9.
    - 0010011 → 13.
    - 0010111 → 11.
    - 0110111 → 15.
    - anything else → 16.
  - 2→3 (load) or 2→5 (store).
  - 3→4 when `mem_ready`, else hold.
  - 4→0.
  - 5→0 when `mem_ready`, else hold.
  - 6→7.
  - 7→0.
  - 8→14.
  - 14→0.
  - 9→10 (jal) or 9→12 (jalr).
  - 10→0 and 12→0.
  - 11→7, 13→7, 15→7.
  - 16 holds if TRAP_STICKY=1, else 16→0.
- Class register: 3-bit opcode class, latched on the DECODE exit edge. MEMADDR and JLINK branch on this register, never on live `opcode`.
- Retire: `instret` increments by 1 on every edge that leaves 4, 5, 7, 10, 12 or 14 for 0. It wraps modulo 2^INSTRET_W. TRAP never retires.
- Stall: with `stall`=1, `state`, the class register and `instret` all hold.

## Timing
- Reset values: `state`=0, class register=0, `instret`=0, `illegal_instr`=0. Reset is asynchronous, so a reset mid-instruction forces state 0 immediately, with no partial retire.
- Moore output: `state` changes only on a `clk` edge, so decoder strobes are valid for the whole cycle.
- Cycles per instruction (no stall, `mem_ready` always 1):
  - load: 5.
  - all others: 4.
  - each cycle with `mem_ready`=0 in 0, 3 or 5 adds one cycle.
- `mem_ready` in any other state is ignored.
- `illegal_instr` is combinational from `state`: it rises in the first TRAP cycle.
- Stall and `mem_ready` together: stall wins; the memory wait is re-evaluated on the next unstalled edge.

## Structure
- Shared package `cu_pkg`:
  - state code localparams S_FETCH..S_TRAP (5-bit);
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_JAL, OP_JALR, OP_IMM, OP_AUIPC, OP_LUI;
  - class encoding CL_LOAD..CL_ILLEGAL.
- One combinational sub-module, `cu_opclass`: maps `opcode` to the 3-bit class. The sequencer uses it both for the DECODE target and for the class register.
- Top-level: state register, class register, `instret` counter and next-state case, in 120–250 lines.

## Test plan
- Reset, then R-type 0110011 with `mem_ready`=1 → state sequence 0,1,6,7,0; `instret` 0→1 on the 7→0 edge.
- Load 0000011 with `mem_ready` low for 2 cycles in S3 → 0,1,2,3,3,3,4,0; `instret`=1 after 8 cycles; store 0100011 → 0,1,2,5,0.
- jal 1101111 → 0,1,9,10,0; jalr 1100111 → 0,1,9,12,0. Change `opcode` to 0110011 during S9: path is unchanged (class is latched).
- Opcode 1111111: TRAP_STICKY=1 → state 16 held for 10 cycles, `illegal_instr`=1, `instret` unchanged; TRAP_STICKY=0 → 16 for one cycle, then 0.
- `stall`=1 for 3 cycles in S6 → state stays 6 and `instret` is frozen; then 7,0. Assert `reset` mid-S3 → `state`=0 before the next edge, `instret`=0.
- INSTRET_W=4: retire 17 instructions → `instret`=1 (wrap).
